// File: rtl/plane_sequencer_if.sv
// rtl/plane_sequencer_if.sv - run request and LED panel drive signals of the plane sequencer
interface plane_sequencer_if #(
    parameter int COL_W = 6,
    parameter int ROW_W = 4
);
    logic             enable;
    logic [5:0]       brightness_mask;
    logic [COL_W-1:0] column;
    logic [ROW_W-1:0] row_address;
    logic             pixel_clk;
    logic             latch;
    logic             oe_n;
    logic             frame_done;

    modport master (
        input  enable,
        output brightness_mask, column, row_address, pixel_clk, latch, oe_n, frame_done
    );

    modport slave (
        output enable,
        input  brightness_mask, column, row_address, pixel_clk, latch, oe_n, frame_done
    );
endinterface

// File: rtl/plane_sequencer.sv
// rtl/plane_sequencer.sv - binary-coded-modulation scan sequencer for a multiplexed LED panel
// Optional PLANE_DIM_EN adds a 3-bit dim input that right-shifts every display time.
module plane_sequencer #(
    parameter int PIXELS_PER_ROW = 64,
    parameter int ROWS           = 16,
    parameter int BASE_ON        = 4
) (
    input logic                clk_in,
    input logic                reset_n,
`ifdef PLANE_DIM_EN
    input logic [2:0]          dim,
`endif
    plane_sequencer_if.master  bus
);
    localparam int COL_W = $clog2(PIXELS_PER_ROW);
    localparam int ROW_W = $clog2(ROWS);
    localparam int ON_W  = $clog2((BASE_ON << 5) + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] row_addr_q, row_addr_d;
    logic [2:0]       plane_q, plane_d;
    logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
    logic             enable_q, enable_d;
    logic             pixel_clk_q, pixel_clk_d;
    logic             latch_q, latch_d;
    logic             oe_n_q, oe_n_d;
    logic             frame_done_q, frame_done_d;
    logic [5:0]       mask_q, mask_d;
    logic [ON_W-1:0]  on_time;
    logic             last_plane, last_row;

    always_comb begin
        on_time = ON_W'(BASE_ON) << plane_q;
`ifdef PLANE_DIM_EN
        on_time = on_time >> dim;
        if (on_time == '0) begin
            on_time = ON_W'(1);
        end
`endif
    end

    assign last_plane = (plane_q == 3'd5);
    assign last_row   = (row_q == ROW_W'(ROWS - 1));

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        col_d        = col_q;
        row_d        = row_q;
        row_addr_d   = row_addr_q;
        plane_d      = plane_q;
        on_cnt_d     = on_cnt_q;
        frame_done_d = 1'b0;
        // Start needs enable on two consecutive IDLE edges, so a run never begins on the first edge out of reset.
        enable_d     = (state_q == IDLE) ? bus.enable : 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable && enable_q) begin
                    state_d = SHIFT;
                    phase_d = 1'b0;
                    col_d   = '0;
                end
            end
            SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    col_d   = col_q + 1'b1;
                    if (col_q == COL_W'(PIXELS_PER_ROW - 1)) begin
                        state_d    = BLANK;
                        row_addr_d = row_q;
                    end
                end
            end
            BLANK: begin
                state_d = LATCH;
            end
            LATCH: begin
                state_d  = DISPLAY;
                on_cnt_d = on_time;
            end
            DISPLAY: begin
                if (on_cnt_q > ON_W'(1)) begin
                    on_cnt_d = on_cnt_q - 1'b1;
                end else begin
                    frame_done_d = last_plane && last_row;
                    if (!bus.enable) begin
                        state_d    = IDLE;
                        plane_d    = '0;
                        row_d      = '0;
                        row_addr_d = '0;
                        col_d      = '0;
                    end else begin
                        state_d = SHIFT;
                        phase_d = 1'b0;
                        if (!last_plane) begin
                            plane_d = plane_q + 3'd1;
                        end else begin
                            plane_d = '0;
                            row_d   = row_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Panel outputs are registered against the state being entered.
        pixel_clk_d = (state_d == SHIFT) && phase_d;
        latch_d     = (state_d == LATCH);
        oe_n_d      = (state_d != DISPLAY);
        mask_d      = 6'b000001 << plane_d;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            row_addr_q   <= '0;
            plane_q      <= '0;
            on_cnt_q     <= '0;
            enable_q     <= 1'b0;
            pixel_clk_q  <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            mask_q       <= 6'b000001;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_addr_q   <= row_addr_d;
            plane_q      <= plane_d;
            on_cnt_q     <= on_cnt_d;
            enable_q     <= enable_d;
            pixel_clk_q  <= pixel_clk_d;
            latch_q      <= latch_d;
            oe_n_q       <= oe_n_d;
            frame_done_q <= frame_done_d;
            mask_q       <= mask_d;
        end
    end

    assign bus.brightness_mask = mask_q;
    assign bus.column          = col_q;
    assign bus.row_address     = row_addr_q;
    assign bus.pixel_clk       = pixel_clk_q;
    assign bus.latch           = latch_q;
    assign bus.oe_n            = oe_n_q;
    assign bus.frame_done      = frame_done_q;
endmodule

// File: tb/tb_plane_sequencer.sv
// tb/tb_plane_sequencer.sv - directed self-checking bench for plane_sequencer
module tb_plane_sequencer;
    localparam int PPR   = 4;
    localparam int NROWS = 2;
    localparam int BON   = 2;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
`ifdef PLANE_DIM_EN
    logic [2:0] dim = 3'd0;
`endif

    plane_sequencer_if #(.COL_W(2), .ROW_W(1)) bus();

    plane_sequencer #(
        .PIXELS_PER_ROW(PPR),
        .ROWS(NROWS),
        .BASE_ON(BON)
    ) dut (
        .clk_in(clk_in),
        .reset_n(reset_n),
`ifdef PLANE_DIM_EN
        .dim(dim),
`endif
        .bus(bus.master)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int errors   = 0;
    int fd_count = 0;

    always @(negedge clk_in) begin
        if (bus.frame_done === 1'b1) fd_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic start();
        reset_n    = 1'b0;
        bus.enable = 1'b0;
        step();
        step();
        reset_n    = 1'b1;
        bus.enable = 1'b1;
    endtask

    task automatic wait_oe_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.oe_n === 1'b0) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic measure(output int len, output logic [5:0] mask, output logic row);
        bit ok;
        wait_oe_low(ok);
        check_eq("display_seen", ok, 1);
        mask = bus.brightness_mask;
        row  = bus.row_address;
        len  = 0;
        while (bus.oe_n === 1'b0 && len < 200) begin
            len++;
            step();
        end
    endtask

    initial begin
        int          len;
        int          base;
        int          hi_cnt;
        int          lo_cnt;
        logic [5:0]  m;
        logic        r;
        bit          ok;

        // reset state and first row/plane timing
        bus.enable = 1'b0;
        step();
        step();
        check_eq("rst_oe_n", bus.oe_n, 1);
        check_eq("rst_pclk", bus.pixel_clk, 0);
        check_eq("rst_latch", bus.latch, 0);
        check_eq("rst_mask", bus.brightness_mask, 6'b000001);
        check_eq("rst_col", bus.column, 0);
        check_eq("rst_row", bus.row_address, 0);
        check_eq("rst_fd", bus.frame_done, 0);
        reset_n    = 1'b1;
        bus.enable = 1'b1;
        step();
        check_eq("idle_pclk", bus.pixel_clk, 0);
        check_eq("idle_oe_n", bus.oe_n, 1);
        for (int c = 0; c < PPR; c++) begin
            step();
            check_eq("shift_lo_pclk", bus.pixel_clk, 0);
            check_eq("shift_lo_col", bus.column, c);
            check_eq("shift_oe_n", bus.oe_n, 1);
            step();
            check_eq("shift_hi_pclk", bus.pixel_clk, 1);
            check_eq("shift_hi_col", bus.column, c);
        end
        step();
        check_eq("blank_oe_n", bus.oe_n, 1);
        check_eq("blank_latch", bus.latch, 0);
        check_eq("blank_pclk", bus.pixel_clk, 0);
        check_eq("blank_row", bus.row_address, 0);
        step();
        check_eq("latch_latch", bus.latch, 1);
        check_eq("latch_oe_n", bus.oe_n, 1);
        for (int k = 0; k < 2; k++) begin
            step();
            check_eq("disp0_oe_n", bus.oe_n, 0);
            check_eq("disp0_latch", bus.latch, 0);
            check_eq("disp0_mask", bus.brightness_mask, 6'b000001);
        end
        step();
        check_eq("disp0_end_oe_n", bus.oe_n, 1);
        check_eq("plane1_mask", bus.brightness_mask, 6'b000010);

        // full frame: all planes of both rows, then wrap
        start();
        base = fd_count;
        for (int rr = 0; rr < NROWS; rr++) begin
            for (int p = 0; p < 6; p++) begin
                measure(len, m, r);
                check_eq("frame_len", len, BON << p);
                check_eq("frame_mask", m, 6'b000001 << p);
                check_eq("frame_row", r, rr);
                if (!(rr == NROWS - 1 && p == 5)) check_eq("frame_fd_early", fd_count - base, 0);
            end
        end
        check_eq("fd_pulse", bus.frame_done, 1);
        check_eq("wrap_mask", bus.brightness_mask, 6'b000001);
        check_eq("wrap_pclk", bus.pixel_clk, 0);
        step();
        check_eq("fd_single_cycle", bus.frame_done, 0);
        check_eq("wrap_pclk_hi", bus.pixel_clk, 1);
        check_eq("wrap_col", bus.column, 0);
        check_eq("fd_count", fd_count - base, 1);
        measure(len, m, r);
        check_eq("wrap_len", len, BON);
        check_eq("wrap_row", r, 0);
        check_eq("wrap_disp_mask", m, 6'b000001);

        // enable dropped during plane 2 display
        start();
        base = fd_count;
        measure(len, m, r);
        check_eq("drop_p0_len", len, BON);
        measure(len, m, r);
        check_eq("drop_p1_len", len, BON << 1);
        wait_oe_low(ok);
        check_eq("drop_p2_seen", ok, 1);
        bus.enable = 1'b0;
        check_eq("drop_p2_mask", bus.brightness_mask, 6'b000100);
        len = 0;
        while (bus.oe_n === 1'b0 && len < 200) begin
            len++;
            step();
        end
        check_eq("drop_p2_len", len, BON << 2);
        check_eq("drop_oe_n", bus.oe_n, 1);
        check_eq("drop_mask", bus.brightness_mask, 6'b000001);
        check_eq("drop_fd", bus.frame_done, 0);
        hi_cnt = 0;
        lo_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.pixel_clk === 1'b1) hi_cnt++;
            if (bus.oe_n === 1'b0) lo_cnt++;
        end
        check_eq("drop_idle_pclk", hi_cnt, 0);
        check_eq("drop_idle_oe", lo_cnt, 0);
        check_eq("drop_fd_count", fd_count - base, 0);

        // asynchronous reset mid-shift
        start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.column === 2'd2 && bus.pixel_clk === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("mid_shift_reached", ok, 1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_oe_n", bus.oe_n, 1);
        check_eq("arst_pclk", bus.pixel_clk, 0);
        check_eq("arst_col", bus.column, 0);
        check_eq("arst_mask", bus.brightness_mask, 6'b000001);
        check_eq("arst_latch", bus.latch, 0);

`ifdef PLANE_DIM_EN
        dim = 3'd2;
        start();
        for (int p = 0; p < 6; p++) begin
            measure(len, m, r);
            check_eq("dim_len", len, ((BON << p) >> 2) == 0 ? 1 : ((BON << p) >> 2));
            check_eq("dim_mask", m, 6'b000001 << p);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/plane_sequencer.md
PLANE_SEQUENCER -- requirements
Module: plane_sequencer

Interface
REQ-001 SHALL have parameter PIXELS_PER_ROW, default 64, number of columns shifted per row (power of two, >=2).
REQ-002 SHALL have parameter ROWS, default 16, number of scan rows (power of two, >=2).
REQ-003 SHALL have parameter BASE_ON, default 4, display cycles for bit plane 0 (>=1).
REQ-004 SHALL have port clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port enable  input  1  run request for the scan sequence.
REQ-007 SHALL have port brightness_mask  output  6  one-hot current bit plane (bit 0 = LSB plane), drives the pixel splitter.
REQ-008 SHALL have port column  output  log2(PIXELS_PER_ROW)  column address of the pixel being shifted.
REQ-009 SHALL have port row_address  output  log2(ROWS)  row driven to the panel.
REQ-010 SHALL have port pixel_clk  output  1  panel shift clock.
REQ-011 SHALL have port latch  output  1  panel latch strobe.
REQ-012 SHALL have port oe_n  output  1  panel output enable, active-low.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-014 SHALL implement states IDLE, SHIFT, BLANK, LATCH, DISPLAY.
REQ-015 IDLE: oe_n=1, pixel_clk=0, latch=0; enable=1 sampled -> SHIFT with plane=0, row=0, column=0.
REQ-016 SHIFT: two cycles per column; first cycle pixel_clk=0 with column stable, second pixel_clk=1; column increments after the high cycle; after column PIXELS_PER_ROW-1 high cycle -> BLANK (2*PIXELS_PER_ROW cycles total).
REQ-017 BLANK: exactly 1 cycle, oe_n=1; row_address updated to the row just shifted -> LATCH.
REQ-018 LATCH: exactly 1 cycle, latch=1, oe_n=1 -> DISPLAY.
REQ-019 DISPLAY: oe_n=0 for exactly BASE_ON << plane cycles, then oe_n=1 next cycle.
REQ-020 Sequence order: plane 0..5 for a row, then next row; column, brightness_mask held stable outside SHIFT.
REQ-021 At end of DISPLAY: plane<5 -> plane+1, SHIFT; plane=5 and row<ROWS-1 -> plane 0, row+1, SHIFT; plane=5 and row=ROWS-1 -> frame_done=1 for 1 cycle, row and plane wrap to 0.
REQ-022 enable SHALL be sampled only in IDLE and at end of DISPLAY; enable=0 at end of DISPLAY -> IDLE, indices cleared, no frame_done unless frame completed that cycle.
REQ-023 brightness_mask SHALL equal 6'b000001 << plane at all times, including in IDLE (plane 0).
REQ-024 On-time counter SHALL be wide enough for BASE_ON<<5 without overflow.
REQ-025 All outputs SHALL be registered (no combinational path from enable to outputs).

Reset
REQ-026 reset_n low SHALL immediately force IDLE, plane=0, row_address=0, column=0, brightness_mask=6'b000001, pixel_clk=0, latch=0, oe_n=1, frame_done=0, regardless of state.
REQ-027 After reset_n release, first SHIFT SHALL start no earlier than the second rising edge with enable=1.

Configuration
REQ-028 Macro PLANE_DIM_EN SHALL, when defined, add input dim (3 bits) and shorten each DISPLAY to max(1, (BASE_ON<<plane) >> dim) cycles, dim sampled on entry to DISPLAY.
REQ-029 Without PLANE_DIM_EN, no dim port SHALL exist and DISPLAY length SHALL be exactly BASE_ON<<plane.

Verification (bench parameters PIXELS_PER_ROW=4, ROWS=2, BASE_ON=2)
REQ-030 Reset then enable=1 -> 8 SHIFT cycles with 4 pixel_clk pulses, column 0,1,2,3, then 1 cycle oe_n=1, 1 latch pulse, oe_n=0 for 2 cycles, mask=000001.
REQ-031 Run one plane sequence -> oe_n low durations 2,4,8,16,32,64 with masks 000001..100000 in order.
REQ-032 Full frame -> row_address 0 then 1, single frame_done pulse after row 1 plane 5 DISPLAY, next SHIFT at row 0 plane 0.
REQ-033 Drop enable during plane 2 DISPLAY -> DISPLAY completes (8 cycles), IDLE entered, oe_n=1, mask=000001, no frame_done.
REQ-034 Assert reset_n low mid-SHIFT at column 2 -> same cycle outputs oe_n=1, pixel_clk=0, column=0, mask=000001.
REQ-035 With PLANE_DIM_EN, dim=2 -> oe_n low durations 1,1,2,4,8,16.
